prio_enc_arb: RTL and testbench
===============================

PRIO_ENC_ARB -- requirements
Module: prio_enc_arb

Interface
REQ-001 Parameter N, default 8: number of request lines, legal range 2..64.
REQ-002 Parameter RR, default 0: 0 selects fixed priority, 1 selects round-robin priority.
REQ-003 Derived W = ceil(log2(N)): width of the index output.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  1  enable; when low, no new capture occurs.
REQ-007 req  input  N  request vector; bit i set means line i is requesting.
REQ-008 out_ready  input  1  downstream accepts the current index when high together with out_valid.
REQ-009 out_valid  output  1  registered; the index register holds an unconsumed result.
REQ-010 out_idx  output  W  registered; encoded index of the selected request line.
REQ-011 out_multi  output  1  registered; more than one req bit was set at capture time.

Function
REQ-012 Slot free = !out_valid || out_ready.
REQ-013 Capture when en=1, req!=0 and the slot is free; out_valid=1, out_idx and out_multi load on the next edge (1-cycle latency).
REQ-014 No-capture condition with a free slot (en=0 or req=0): out_valid clears to 0 on the next edge; out_idx and out_multi hold their last values.
REQ-015 If out_valid=1 and out_ready=0: out_valid, out_idx and out_multi hold, regardless of req or en.
REQ-016 Back-to-back operation: out_valid=1, out_ready=1 and capture conditions met in the same cycle give a new result on the next edge with no bubble.
REQ-017 Fixed mode (RR=0): the highest set index wins; search order N-1 down to 0.
REQ-018 Round-robin mode (RR=1): internal pointer L, W bits; search order L-1, L-2, ... 0, N-1, ... L, with wrap modulo N.
REQ-019 L updates to the accepted out_idx only on an accept edge (out_valid && out_ready); a capture alone does not move L.
REQ-020 With L=0, RR order equals fixed order.
REQ-021 If only line L is requesting, line L is selected last in order and is still granted.
REQ-022 In fixed mode L is unused and stays 0.
REQ-023 req is sampled only at the capture edge; changes to req while a result is held do not alter out_idx.
REQ-024 out_multi = 1 iff popcount(req) >= 2 at capture.
REQ-025 Non-power-of-two N: out_idx never exceeds N-1, and the RR wrap is modulo N, not 2^W.

Reset
REQ-026 rst_n=0 at an edge sets out_valid=0, out_idx=0, out_multi=0 and L=0, overriding every other input.
REQ-027 Reset asserted while a result is pending discards that result; the first capture after release follows REQ-013 with L=0.
REQ-028 No output is ever X after the first reset edge; no output is ever high-impedance.

Verification (N=8)
REQ-029 RR=0, en=1, req=8'b0000_0011, out_ready=1 -> next cycle out_valid=1, out_idx=1, out_multi=1.
REQ-030 RR=0, req=8'b1000_1000, out_ready=0 for 3 cycles, req then changed to 8'b0000_0001 -> out_idx stays 7; after out_ready=1 the next result is 0.
REQ-031 RR=0, en=0, req=8'b0000_1010 -> out_valid stays 0; raising en -> out_idx=3 one cycle later.
REQ-032 RR=1, req=8'hFF held, out_ready=1 continuously -> out_idx sequence is 7,6,5,4,3,2,1,0,7, accepting every cycle.
REQ-033 RR=1, req=8'b1000_0001 held, out_ready=1 -> alternating grants 7,0,7,0; single req=8'b0000_0100 -> 2 granted repeatedly.
REQ-034 rst_n=0 for one edge while out_valid=1 and out_ready=0 -> all outputs 0 next cycle; RR order restarts from 7.

Source files
------------

// File: rtl/prio_enc_arb.sv
// Priority-encoding arbiter with a one-deep output register and ready/valid handshake.
// RR=0 grants the highest requesting line; RR=1 rotates priority past the last accepted line.
module prio_enc_arb #(
    parameter int N  = 8,
    parameter int RR = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi
);

    logic         slot_free;
    logic         capture;
    logic         accept;
    logic [W-1:0] ptr;
    logic [W-1:0] eff_ptr;
    logic [N-1:0] low_mask;
    logic [N-1:0] low_req;
    logic [W-1:0] sel_idx;
    logic         multi;

    // Highest set bit of v; the ascending scan leaves the last (highest) hit.
    function automatic logic [W-1:0] top_idx(input logic [N-1:0] v);
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) top_idx = W'(i);
        end
    endfunction

    assign slot_free = !out_valid || out_ready;
    assign capture   = en && (|req) && slot_free;
    assign accept    = out_valid && out_ready;

    // A capture on an accept edge must already search from the line being accepted.
    assign eff_ptr = (RR != 0 && accept) ? out_idx : ptr;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        low_mask = '0;
        for (int i = 0; i < N; i++) begin
            low_mask[i] = (i < int'(eff_ptr));
        end
    end

    // Lines below the pointer are searched first; otherwise the plain top-down order
    // covers the pointer and above, wrapping modulo N rather than 2^W.
    assign low_req = req & low_mask;
    assign sel_idx = (|low_req) ? top_idx(low_req) : top_idx(req);
    assign multi   = |(req & (req - N'(1)));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_multi <= 1'b0;
            ptr       <= '0;
        end else begin
            if (RR != 0 && accept) begin
                ptr <= out_idx;
            end
            if (slot_free) begin
                out_valid <= capture;
                if (capture) begin
                    out_idx   <= sel_idx;
                    out_multi <= multi;
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb: fixed N=8, round-robin N=8 and round-robin N=5 instances
// driven from shared inputs; directed tables, hand sequences and a randomized model check.
module tb_prio_enc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ready;

    logic       fx_valid, fx_multi;
    logic [2:0] fx_idx;
    logic       rr_valid, rr_multi;
    logic [2:0] rr_idx;
    logic       r5_valid, r5_multi;
    logic [2:0] r5_idx;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic valid;
        int   idx;
        logic multi;
        int   lptr;
    } mstate_t;

    mstate_t m_fx, m_rr, m_r5;

    typedef struct {
        bit       rst_n;
        bit       en;
        bit [7:0] req;
        bit       ready;
        bit       exp_valid;
        int       exp_idx;
        bit       exp_multi;
    } vec_t;

    prio_enc_arb #(.N(8), .RR(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(ready),
        .out_valid(fx_valid), .out_idx(fx_idx), .out_multi(fx_multi)
    );

    prio_enc_arb #(.N(8), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(ready),
        .out_valid(rr_valid), .out_idx(rr_idx), .out_multi(rr_multi)
    );

    prio_enc_arb #(.N(5), .RR(1)) dut_r5 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req[4:0]), .out_ready(ready),
        .out_valid(r5_valid), .out_idx(r5_idx), .out_multi(r5_multi)
    );

    always #5 clk = ~clk;

    // Reference: walk the priority list L-1, L-2, ... wrapping modulo n, first requester wins.
    function automatic mstate_t model_step(mstate_t s, int n, bit rr, bit rst, bit e,
                                           logic [7:0] r, bit rdy);
        mstate_t t;
        int      base;
        int      cnt;
        int      c;
        bit      found;
        t = s;
        if (!rst) begin
            t.valid = 1'b0;
            t.idx   = 0;
            t.multi = 1'b0;
            t.lptr  = 0;
            return t;
        end
        base = s.lptr;
        if (rr && s.valid && rdy) begin
            t.lptr = s.idx;
            base   = s.idx;
        end
        if (!s.valid || rdy) begin
            cnt = 0;
            for (int i = 0; i < n; i++) if (r[i]) cnt++;
            if (e && cnt > 0) begin
                t.valid = 1'b1;
                t.multi = (cnt >= 2);
                found   = 1'b0;
                for (int k = 1; k <= n; k++) begin
                    c = (base - k + n) % n;
                    if (!found && r[c]) begin
                        t.idx = c;
                        found = 1'b1;
                    end
                end
            end else begin
                t.valid = 1'b0;
            end
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_fx = model_step(m_fx, 8, 1'b0, rst_n, en, req, ready);
        m_rr = model_step(m_rr, 8, 1'b1, rst_n, en, req, ready);
        m_r5 = model_step(m_r5, 5, 1'b1, rst_n, en, req, ready);
    endtask

    task automatic drive(input bit r, input bit e, input logic [7:0] q, input bit rdy);
        rst_n = r;
        en    = e;
        req   = q;
        ready = rdy;
    endtask

    task automatic expect_rr8(input string nm, input int idx, input bit mul);
        check({nm, ".valid"}, 32'(rr_valid), 32'(1));
        check({nm, ".idx"},   32'(rr_idx),   32'(idx));
        check({nm, ".multi"}, 32'(rr_multi), 32'(mul));
    endtask

    vec_t vecs[20];

    initial begin
        m_fx = '{1'b0, 0, 1'b0, 0};
        m_rr = '{1'b0, 0, 1'b0, 0};
        m_r5 = '{1'b0, 0, 1'b0, 0};
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Fixed-priority table; state carries from row to row.
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 7, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 7, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 7, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h0A, 1'b0, 1'b0, 7, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h0A, 1'b0, 1'b1, 3, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b1, 3, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 7, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 7, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 7, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 7, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 7, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 8'h24, 1'b0, 1'b1, 5, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].ready);
            tick();
            check($sformatf("fix_row%0d.valid", i), 32'(fx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("fix_row%0d.idx", i),   32'(fx_idx),   32'(vecs[i].exp_idx));
            check($sformatf("fix_row%0d.multi", i), 32'(fx_multi), 32'(vecs[i].exp_multi));
        end

        // Round-robin full rotation, N=8 and N=5 side by side.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_rr8($sformatf("rr_rot%0d", k), (7 - k + 8) % 8, 1'b1);
            check($sformatf("r5_rot%0d.valid", k), 32'(r5_valid), 32'(1));
            check($sformatf("r5_rot%0d.idx", k),   32'(r5_idx),   32'((4 - k + 10) % 5));
        end

        // Two requesters alternate, then a lone requester keeps winning.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h81, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_rr8($sformatf("rr_alt%0d", k), (k % 2 == 0) ? 7 : 0, 1'b1);
        end
        req = 8'h04;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_rr8($sformatf("rr_single%0d", k), 2, 1'b0);
        end

        // Reset while a result is held discards it and restarts the rotation.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        expect_rr8("rr_pre0", 7, 1'b1);
        tick();
        expect_rr8("rr_pre1", 6, 1'b1);
        ready = 1'b0;
        tick();
        expect_rr8("rr_hold", 6, 1'b1);
        rst_n = 1'b0;
        tick();
        check("rr_rst.valid", 32'(rr_valid), 32'(0));
        check("rr_rst.idx",   32'(rr_idx),   32'(0));
        check("rr_rst.multi", 32'(rr_multi), 32'(0));
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        tick();
        expect_rr8("rr_post0", 7, 1'b1);
        tick();
        expect_rr8("rr_post1", 6, 1'b1);

        // Randomized run against the reference model for all three instances.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            en    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'(1 << $urandom_range(0, 7));
                2:       req = 8'($urandom & $urandom);
                default: req = 8'($urandom);
            endcase
            ready = ($urandom_range(0, 2) != 0);
            tick();
            check("rnd_fx.valid", 32'(fx_valid), 32'(m_fx.valid));
            check("rnd_fx.idx",   32'(fx_idx),   32'(m_fx.idx));
            check("rnd_fx.multi", 32'(fx_multi), 32'(m_fx.multi));
            check("rnd_rr.valid", 32'(rr_valid), 32'(m_rr.valid));
            check("rnd_rr.idx",   32'(rr_idx),   32'(m_rr.idx));
            check("rnd_rr.multi", 32'(rr_multi), 32'(m_rr.multi));
            check("rnd_r5.valid", 32'(r5_valid), 32'(m_r5.valid));
            check("rnd_r5.idx",   32'(r5_idx),   32'(m_r5.idx));
            check("rnd_r5.multi", 32'(r5_multi), 32'(m_r5.multi));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
